alu_op_sequencer: RTL
=====================

# alu_op_sequencer

Sequencer between instruction decode and the shared single-cycle ALU.
- Accepts one operation at a time over a valid/ready handshake.
- Decodes `alu_op`/`funct` into the team's 4-bit ALU control code.
- Issues single-cycle codes to the external ALU and captures its result.
- Executes multiply (code 0101) and divide (code 0110) itself as N-cycle iterative operations.
- Returns every result over a second valid/ready handshake, so the core can stall on long operations.

## Interface
Parameters:
- `N`, 32, operand/result width
- `FUNCT_W`, 6, funct field width
- `OP_W`, 2, ALU_Op width
- `CTRL_W`, 4, ALU control width

Ports:
- `clk` in 1 — the block's single clock
- `rst` in 1 — synchronous, active-high reset
- `req_valid` in 1 — request present
- `req_ready` out 1 — block can accept a request
- `alu_op` in OP_W — ALU_Op from the main decoder
- `funct` in FUNCT_W — funct field
- `src_a` in N — operand A
- `src_b` in N — operand B
- `alu_ctrl` out CTRL_W — control code to the shared ALU
- `alu_a` out N — operand A to the shared ALU
- `alu_b` out N — operand B to the shared ALU
- `alu_y` in N — combinational ALU result
- `rsp_valid` out 1 — result present
- `rsp_ready` in 1 — consumer accepts the result
- `result` out N — operation result
- `div_by_zero` out 1 — flag qualified by rsp_valid
- `illegal` out 1 — flag qualified by rsp_valid; decode produced 0000
- `busy` out 1 — state is not IDLE

## Operation
- Decode table (bit-exact):
  - ALU_Op 00 → 0001
  - ALU_Op 01 → 0010
  - ALU_Op 10 with funct 0–9 → 0011–1100 in order (add, sub, mul, div, or, and, xor, sll, srl, slt)
  - any other ALU_Op/funct combination → 0000
- ALU_Op 00 and 01 ignore funct entirely in this block.
- States:
  - IDLE: `req_ready`=1. On accept, latch the operands and decoded code, then go to:
    - ILL if the code is 0000
    - MUL if the code is 0101
    - DIV if the code is 0110
    - EXE otherwise
  - EXE: drive `alu_ctrl`, `alu_a`, `alu_b` from the latches; capture `alu_y` at the clock edge; go to DONE.
  - MUL: unsigned shift-add, one multiplier bit per cycle, count N cycles. Keep the low N bits of the product; overflow is discarded. Go to DONE.
  - DIV: unsigned restoring division, one quotient bit per cycle, N cycles; result is the quotient.
    - If the latched B is 0, skip the iterations, set `result` to all ones and `div_by_zero`=1, and go to DONE.
  - ILL: `result`=0, `illegal`=1; go to DONE.
  - DONE: `rsp_valid`=1; outputs are held stable until `rsp_valid && rsp_ready`, then go to IDLE.
- Outside EXE, `alu_ctrl`=0000 and `alu_a`=`alu_b`=0, so the shared ALU sees no spurious operation.
- `req_ready` is low in every state except IDLE. A request held during busy states waits and is never dropped.
- Reset mid-operation aborts immediately: the state returns to IDLE and the partial result is discarded.

## Timing
- All outputs are registered.
- Reset values: `req_ready`=1, `rsp_valid`=0, `busy`=0, `result`=0, `div_by_zero`=0, `illegal`=0, `alu_ctrl`=0000, `alu_a`=0, `alu_b`=0.
- Latency counts cycles from the accept edge to the first `rsp_valid`=1:
  - EXE codes: 2
  - illegal: 2
  - divide by zero: 2
  - mul/div: N+1
- A new request can be accepted no earlier than the cycle after the response handshake completes; there is no overlap (1 outstanding).
- If `rsp_ready` is already high when `rsp_valid` rises, the handshake completes in that cycle and `req_ready` is 1 on the next cycle.

## Configuration
- Macro `ALU_SEQ_SIGNED_EN`.
- Defined: mul/div are two's-complement.
  - Operands are converted to magnitudes on accept; the sign is corrected in one extra cycle (SIGN state) before DONE, giving mul/div latency N+2.
  - Divide by zero still returns all ones.
  - The most-negative value divided by −1 returns the most-negative value.
- Undefined: unsigned only, with no SIGN state.

## Structure
- Package `alu_seq_pkg`:
  - enum `alu_ctrl_t` holding the 13 control codes (0000–1100)
  - enum `seq_state_t`
  - localparam `CTRL_MUL`
  - localparam `CTRL_DIV`
- Sub-module `alu_seq_iter_unit` holds the shared shift-add/restoring datapath: accumulator, shift register and N-cycle counter, with start/done ports. The top level holds the decode logic, FSM and handshakes.

## Test plan
- ALU_Op=00, A=5, B=7, bench ALU model returns A+B → `alu_ctrl`=0001 during EXE; `rsp_valid` 2 cycles after accept; `result`=12.
- ALU_Op=10, funct=2, A=6, B=7, `rsp_ready` held high → `rsp_valid` at cycle N+1 (33); `result`=42; `alu_ctrl` stays 0000 throughout.
- ALU_Op=10, funct=3:
  - A=100, B=7 → `result`=14
  - A=9, B=0 → `result`=FFFFFFFF with `div_by_zero`=1 at latency 2
- ALU_Op=10, funct=12 → `illegal`=1, `result`=0; a request held during `busy` is accepted only after the response handshake completes.
- `rsp_ready` held low for 5 cycles → `result`/flags stable and `req_ready`=0; then assert `rsp_ready` → `req_ready`=1 on the next cycle.
- Assert `rst` at cycle 10 of a multiply → next cycle `busy`=0, `rsp_valid`=0, `req_ready`=1; with `ALU_SEQ_SIGNED_EN`, −6×7 = FFFFFFD6 at latency 34.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU op sequencer: ALU control codes, FSM states and
// the codes the sequencer executes itself.
package alu_seq_pkg;

   typedef enum logic [3:0] {
      ALU_NOP    = 4'b0000,
      ALU_MEM    = 4'b0001,
      ALU_BRANCH = 4'b0010,
      ALU_ADD    = 4'b0011,
      ALU_SUB    = 4'b0100,
      ALU_MUL    = 4'b0101,
      ALU_DIV    = 4'b0110,
      ALU_OR     = 4'b0111,
      ALU_AND    = 4'b1000,
      ALU_XOR    = 4'b1001,
      ALU_SLL    = 4'b1010,
      ALU_SRL    = 4'b1011,
      ALU_SLT    = 4'b1100
   } alu_ctrl_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXE,
      S_MUL,
      S_DIV,
      S_ILL,
      S_SIGN,
      S_DONE
   } seq_state_t;

   localparam alu_ctrl_t CTRL_MUL = ALU_MUL;
   localparam alu_ctrl_t CTRL_DIV = ALU_DIV;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, response and shared-ALU bus of the op sequencer.
// master = decode/core side (also models the ALU), slave = the sequencer.
interface alu_op_sequencer_if #(
   parameter int N       = 32,
   parameter int FUNCT_W = 6,
   parameter int OP_W    = 2,
   parameter int CTRL_W  = 4
);
   logic               req_valid;
   logic               req_ready;
   logic [OP_W-1:0]    alu_op;
   logic [FUNCT_W-1:0] funct;
   logic [N-1:0]       src_a;
   logic [N-1:0]       src_b;
   logic [CTRL_W-1:0]  alu_ctrl;
   logic [N-1:0]       alu_a;
   logic [N-1:0]       alu_b;
   logic [N-1:0]       alu_y;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [N-1:0]       result;
   logic               div_by_zero;
   logic               illegal;
   logic               busy;

   modport master (
      output req_valid, alu_op, funct, src_a, src_b, alu_y, rsp_ready,
      input  req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, result,
             div_by_zero, illegal, busy
   );

   modport slave (
      input  req_valid, alu_op, funct, src_a, src_b, alu_y, rsp_ready,
      output req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, result,
             div_by_zero, illegal, busy
   );
endinterface

// File: rtl/alu_seq_iter_unit.sv
// Shared iterative datapath: unsigned shift-add multiply (low N bits) and
// restoring divide (quotient), one bit per cycle, N-cycle down-counter.
module alu_seq_iter_unit #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         is_div,
   input  logic [N-1:0] op_a,
   input  logic [N-1:0] op_b,
   output logic         last,
   output logic [N-1:0] y_next
);
   localparam int CW = $clog2(N + 1);

   logic [N-1:0]  acc, sh, opnd;
   logic [N-1:0]  acc_nx, sh_nx, opnd_nx;
   logic [N:0]    diff;
   logic          div_mode;
   logic [CW-1:0] cnt;

   // Divide: acc is the partial remainder, sh the dividend turning into the
   // quotient. Multiply: acc is the product, sh the multiplier, opnd the
   // left-shifting multiplicand.
   always_comb begin
      diff    = {acc, sh[N-1]} - {1'b0, opnd};
      acc_nx  = acc + (sh[0] ? opnd : '0);
      sh_nx   = {1'b0, sh[N-1:1]};
      opnd_nx = opnd << 1;
      if (div_mode) begin
         acc_nx  = diff[N] ? {acc[N-2:0], sh[N-1]} : diff[N-1:0];
         sh_nx   = {sh[N-2:0], ~diff[N]};
         opnd_nx = opnd;
      end
   end

   assign y_next = div_mode ? sh_nx : acc_nx;
   assign last   = (cnt == CW'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         sh       <= '0;
         opnd     <= '0;
         div_mode <= 1'b0;
         cnt      <= '0;
      end else if (start) begin
         acc      <= '0;
         sh       <= is_div ? op_a : op_b;
         opnd     <= is_div ? op_b : op_a;
         div_mode <= is_div;
         cnt      <= CW'(N);
      end else if (cnt != '0) begin
         acc  <= acc_nx;
         sh   <= sh_nx;
         opnd <= opnd_nx;
         cnt  <= cnt - CW'(1);
      end
   end
endmodule

// File: rtl/alu_op_sequencer.sv
// Sequencer between decode and the shared single-cycle ALU; runs mul/div itself.
// Define ALU_SEQ_SIGNED_EN for two's-complement mul/div (adds the SIGN state).
//
// state | meaning
// IDLE  | req_ready=1, waiting for a request
// EXE   | shared ALU driven from the latches, alu_y captured
// MUL   | N shift-add iterations
// DIV   | N restoring iterations, or immediate all-ones on B=0
// ILL   | decode gave 0000, result 0 with illegal set
// SIGN  | sign correction of the mul/div magnitude result
// DONE  | rsp_valid=1, outputs held until rsp_ready
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int N       = 32,
   parameter int FUNCT_W = 6,
   parameter int OP_W    = 2,
   parameter int CTRL_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   alu_op_sequencer_if.slave bus
);

   function automatic alu_ctrl_t decode(input logic [OP_W-1:0] op, input logic [FUNCT_W-1:0] f);
      alu_ctrl_t c;
      c = ALU_NOP;
      if (op == OP_W'(0))
         c = ALU_MEM;
      else if (op == OP_W'(1))
         c = ALU_BRANCH;
      else if (op == OP_W'(2) && f <= FUNCT_W'(9))
         c = alu_ctrl_t'(4'(f) + 4'd3);
      return c;
   endfunction

   seq_state_t   state;
   alu_ctrl_t    dec;
   logic         accept;
   logic         iter_start;
   logic         iter_last;
   logic [N-1:0] iter_y;
   logic [N-1:0] mag_a, mag_b;
   logic         b_zero;

   assign dec        = decode(bus.alu_op, bus.funct);
   assign accept     = bus.req_valid && bus.req_ready;
   assign iter_start = accept && (dec == CTRL_MUL || dec == CTRL_DIV);

`ifdef ALU_SEQ_SIGNED_EN
   logic neg;
   assign mag_a = bus.src_a[N-1] ? -bus.src_a : bus.src_a;
   assign mag_b = bus.src_b[N-1] ? -bus.src_b : bus.src_b;
`else
   assign mag_a = bus.src_a;
   assign mag_b = bus.src_b;
`endif

   alu_seq_iter_unit #(.N(N)) u_iter (
      .clk    (clk),
      .rst    (rst),
      .start  (iter_start),
      .is_div (dec == CTRL_DIV),
      .op_a   (mag_a),
      .op_b   (mag_b),
      .last   (iter_last),
      .y_next (iter_y)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         bus.req_ready   <= 1'b1;
         bus.rsp_valid   <= 1'b0;
         bus.busy        <= 1'b0;
         bus.result      <= '0;
         bus.div_by_zero <= 1'b0;
         bus.illegal     <= 1'b0;
         bus.alu_ctrl    <= '0;
         bus.alu_a       <= '0;
         bus.alu_b       <= '0;
         b_zero          <= 1'b0;
`ifdef ALU_SEQ_SIGNED_EN
         neg             <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               bus.req_ready   <= 1'b0;
               bus.busy        <= 1'b1;
               bus.div_by_zero <= 1'b0;
               bus.illegal     <= 1'b0;
               b_zero          <= (bus.src_b == '0);
`ifdef ALU_SEQ_SIGNED_EN
               neg             <= bus.src_a[N-1] ^ bus.src_b[N-1];
`endif
               if (dec == ALU_NOP)
                  state <= S_ILL;
               else if (dec == CTRL_MUL)
                  state <= S_MUL;
               else if (dec == CTRL_DIV)
                  state <= S_DIV;
               else begin
                  state        <= S_EXE;
                  bus.alu_ctrl <= CTRL_W'(dec);
                  bus.alu_a    <= bus.src_a;
                  bus.alu_b    <= bus.src_b;
               end
            end
            S_EXE: begin
               bus.result    <= bus.alu_y;
               bus.alu_ctrl  <= '0;
               bus.alu_a     <= '0;
               bus.alu_b     <= '0;
               bus.rsp_valid <= 1'b1;
               state         <= S_DONE;
            end
            S_MUL, S_DIV: begin
               if (state == S_DIV && b_zero) begin
                  bus.result      <= '1;
                  bus.div_by_zero <= 1'b1;
                  bus.rsp_valid   <= 1'b1;
                  state           <= S_DONE;
               end else if (iter_last) begin
                  bus.result <= iter_y;
`ifdef ALU_SEQ_SIGNED_EN
                  state      <= S_SIGN;
`else
                  bus.rsp_valid <= 1'b1;
                  state         <= S_DONE;
`endif
               end
            end
            S_ILL: begin
               bus.result    <= '0;
               bus.illegal   <= 1'b1;
               bus.rsp_valid <= 1'b1;
               state         <= S_DONE;
            end
`ifdef ALU_SEQ_SIGNED_EN
            // Negating the magnitude of MIN / -1 yields MIN again.
            S_SIGN: begin
               if (neg)
                  bus.result <= -bus.result;
               bus.rsp_valid <= 1'b1;
               state         <= S_DONE;
            end
`endif
            S_DONE: if (bus.rsp_ready) begin
               bus.rsp_valid <= 1'b0;
               bus.req_ready <= 1'b1;
               bus.busy      <= 1'b0;
               state         <= S_IDLE;
            end
            default: begin
               bus.rsp_valid <= 1'b0;
               bus.req_ready <= 1'b1;
               bus.busy      <= 1'b0;
               state         <= S_IDLE;
            end
         endcase
      end
   end
endmodule
